// File: rtl/adc_trigger_gen.sv
`default_nettype none
// ============================================================================
// Module  : adc_trigger_gen
// Brief   : Hysteresis trigger on a synchronised ADC stream, with period
//           measurement and lock detection. Define ADC_TRIG_GLITCH_FILTER_EN
//           to require two consecutive samples before trig_out changes.
// Revision: 1.0 - initial release
// ============================================================================
module adc_trigger_gen #(
  parameter int PERIOD_W   = 16,
  parameter int TOL        = 2,
  parameter int STABLE_CNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adc_clk,
  input  logic [11:0]         adc_data,
  input  logic [11:0]         trig_level,
  input  logic [11:0]         trig_hyst,
  output logic                trig_out,
  output logic                stable,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam int                  c_match_w    = $clog2(STABLE_CNT + 1);
  localparam logic [PERIOD_W-1:0] c_cnt_max    = '1;
  localparam logic [PERIOD_W-1:0] c_cnt_near   = c_cnt_max - PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] c_tol        = PERIOD_W'(TOL);
  localparam logic [c_match_w-1:0] c_match_full = c_match_w'(STABLE_CNT);

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // adc_clk synchroniser, edge detect and sample capture
  // --------------------------------------------------------------------------
  logic        r_adc_s1;
  logic        r_adc_s2;
  logic        r_adc_prev;
  logic        r_eval;
  logic [11:0] r_sample;
  logic        w_strobe;
  logic        w_eval;

  assign w_strobe = r_adc_s2 & ~r_adc_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adc_s1   <= 1'b0;
      r_adc_s2   <= 1'b0;
      r_adc_prev <= 1'b0;
      r_eval     <= 1'b0;
      r_sample   <= '0;
    end else begin
      r_adc_s1   <= adc_clk;
      r_adc_s2   <= r_adc_s1;
      r_adc_prev <= r_adc_s2;
      r_eval     <= w_strobe;
      if (w_strobe) begin
        r_sample <= adc_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturated thresholds and comparator
  // --------------------------------------------------------------------------
  logic [12:0] w_sum;
  logic [12:0] w_diff;
  logic [11:0] w_hi_th;
  logic [11:0] w_lo_th;
  logic        w_hi_hit;
  logic        w_lo_hit;
  logic        w_set;
  logic        w_clr;
  logic        w_trig_next;
  logic        w_rise;

  assign w_sum    = {1'b0, trig_level} + {1'b0, trig_hyst};
  assign w_diff   = {1'b0, trig_level} - {1'b0, trig_hyst};
  assign w_hi_th  = w_sum[12]  ? 12'hFFF : w_sum[11:0];
  assign w_lo_th  = w_diff[12] ? 12'h000 : w_diff[11:0];
  assign w_hi_hit = (r_sample >= w_hi_th);
  assign w_lo_hit = (r_sample <  w_lo_th);

`ifdef ADC_TRIG_GLITCH_FILTER_EN
  // The extra evaluation stage keeps the filtered path one clk behind.
  logic r_eval_d;
  logic r_hi_prev;
  logic r_lo_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval_d  <= 1'b0;
      r_hi_prev <= 1'b0;
      r_lo_prev <= 1'b0;
    end else begin
      r_eval_d <= r_eval;
      if (w_eval) begin
        r_hi_prev <= w_hi_hit;
        r_lo_prev <= w_lo_hit;
      end
    end
  end

  assign w_eval = r_eval_d;
  assign w_set  = w_hi_hit & r_hi_prev;
  assign w_clr  = w_lo_hit & r_lo_prev;
`else
  assign w_eval = r_eval;
  assign w_set  = w_hi_hit;
  assign w_clr  = w_lo_hit;
`endif

  assign w_trig_next = w_set ? 1'b1 : (w_clr ? 1'b0 : trig_out);
  assign w_rise      = w_eval & w_trig_next & ~trig_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_out <= 1'b0;
    end else if (w_eval) begin
      trig_out <= w_trig_next;
    end
  end

  // --------------------------------------------------------------------------
  // Period measurement and lock FSM
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [PERIOD_W-1:0]  r_cnt;
  logic [PERIOD_W-1:0]  r_prev_p;
  logic                 r_prev_vld;
  logic [c_match_w-1:0] r_match;
  logic [PERIOD_W-1:0]  w_delta;
  logic                 w_in_tol;
  logic [c_match_w-1:0] w_match_next;
  logic                 w_timeout;

  // A sample that would push cnt to saturation ends the measurement, even if
  // it is also a rising event.
  assign w_timeout = w_eval && (r_state != WAIT_EDGE) && (r_cnt >= c_cnt_near);

  assign w_delta  = (r_cnt >= r_prev_p) ? (r_cnt - r_prev_p) : (r_prev_p - r_cnt);
  assign w_in_tol = r_prev_vld && (w_delta <= c_tol);

  assign w_match_next = !w_in_tol                ? '0      :
                        (r_match == c_match_full) ? r_match :
                                                    r_match + c_match_w'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_EDGE;
      r_cnt        <= '0;
      r_prev_p     <= '0;
      r_prev_vld   <= 1'b0;
      r_match      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stable       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (w_timeout) begin
        r_state    <= WAIT_EDGE;
        r_cnt      <= c_cnt_max;
        r_prev_p   <= '0;
        r_prev_vld <= 1'b0;
        r_match    <= '0;
        stable     <= 1'b0;
      end else if (w_rise) begin
        r_cnt <= PERIOD_W'(1);
        if (r_state == WAIT_EDGE) begin
          r_state <= MEASURE;
        end else begin
          period       <= r_cnt;
          period_valid <= 1'b1;
          r_prev_p     <= r_cnt;
          r_prev_vld   <= 1'b1;
          r_match      <= w_match_next;
          if (w_match_next == c_match_full) begin
            r_state <= LOCKED;
            stable  <= 1'b1;
          end else begin
            r_state <= MEASURE;
            stable  <= 1'b0;
          end
        end
      end else if (w_eval && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + PERIOD_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_trigger_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_trigger_gen
// Brief   : Self-checking bench for adc_trigger_gen with a sample-level model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_trigger_gen;

  localparam int PW   = 6;
  localparam int TOLV = 2;
  localparam int SC   = 4;
  localparam int MAXC = (1 << PW) - 1;
`ifdef ADC_TRIG_GLITCH_FILTER_EN
  localparam int FD = 1;
`else
  localparam int FD = 0;
`endif

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          adc_clk    = 1'b0;
  logic [11:0]   adc_data   = 12'd0;
  logic [11:0]   trig_level = 12'd2048;
  logic [11:0]   trig_hyst  = 12'd32;
  logic          trig_out;
  logic          stable;
  logic [PW-1:0] period;
  logic          period_valid;

  int checks   = 0;
  int failures = 0;

  adc_trigger_gen #(
    .PERIOD_W  (PW),
    .TOL       (TOLV),
    .STABLE_CNT(SC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_clk     (adc_clk),
    .adc_data    (adc_data),
    .trig_level  (trig_level),
    .trig_hyst   (trig_hyst),
    .trig_out    (trig_out),
    .stable      (stable),
    .period      (period),
    .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  // Reference model: one call per ADC sample, following the behavioural rules.
  bit m_trig, m_armed, m_have_prev, m_stable, m_pv, m_prev_hi, m_prev_lo;
  int m_since, m_prev_p, m_match, m_period;
  int o_pv_cnt, o_period;

  task automatic model_reset();
    m_trig = 0; m_armed = 0; m_have_prev = 0; m_stable = 0; m_pv = 0;
    m_prev_hi = 0; m_prev_lo = 0;
    m_since = 0; m_prev_p = 0; m_match = 0; m_period = 0;
  endtask

  task automatic model_step(input int v);
    int hi, lo, d;
    bit hit_hi, hit_lo, set, clr, nt, rise;
    hi = int'(trig_level) + int'(trig_hyst);
    if (hi > 4095) hi = 4095;
    lo = int'(trig_level) - int'(trig_hyst);
    if (lo < 0) lo = 0;
    hit_hi = (v >= hi);
    hit_lo = (v < lo);
    set = hit_hi && (FD == 0 || m_prev_hi);
    clr = hit_lo && (FD == 0 || m_prev_lo);
    m_prev_hi = hit_hi;
    m_prev_lo = hit_lo;
    nt = set ? 1'b1 : (clr ? 1'b0 : m_trig);
    rise = nt && !m_trig;
    m_trig = nt;
    m_pv = 0;
    if (m_armed && (m_since + 1 >= MAXC)) begin
      m_armed = 0; m_have_prev = 0; m_match = 0; m_stable = 0; m_since = MAXC;
    end else if (rise) begin
      if (m_armed) begin
        m_pv = 1;
        m_period = m_since;
        d = m_since - m_prev_p;
        if (d < 0) d = -d;
        if (m_have_prev && d <= TOLV) m_match = (m_match < SC) ? m_match + 1 : SC;
        else m_match = 0;
        m_stable = (m_match == SC);
        m_prev_p = m_since;
        m_have_prev = 1;
      end
      m_armed = 1;
      m_since = 1;
    end else if (m_since < MAXC) begin
      m_since++;
    end
  endtask

  // One ADC sample: 4 clk high, 4 clk low; period_valid pulses are collected.
  task automatic send_sample(input int v);
    adc_data = 12'(v);
    adc_clk  = 1'b1;
    o_pv_cnt = 0;
    o_period = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) adc_clk = 1'b0;
      if (period_valid) begin
        o_pv_cnt++;
        o_period = int'(period);
      end
    end
    model_step(v);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (trig_out !== 1'b0) begin failures++; $display("FAIL reset_trig: got %b expected 0", trig_out); end
    checks++; if (stable !== 1'b0) begin failures++; $display("FAIL reset_stable: got %b expected 0", stable); end
    checks++; if (period !== '0) begin failures++; $display("FAIL reset_period: got %0d expected 0", period); end
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL reset_pv: got %b expected 0", period_valid); end
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    checks++; if (trig_out !== 1'b0 || period_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: got trig=%b pv=%b expected 0 0", trig_out, period_valid);
    end
  endtask

  task automatic test_lock();
    int waves[9] = '{8, 8, 8, 8, 8, 8, 10, 11, 14};
    int exp_p[9] = '{8, 8, 8, 8, 8, 8, 10, 11, 14};
    bit exp_s[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int nrep, len;
    nrep = 0;
    trig_level = 12'd2048; trig_hyst = 12'd32;
    repeat (3) send_sample(0);
    for (int w = 0; w < 10; w++) begin
      len = (w < 9) ? waves[w] : 2;
      for (int s = 0; s < len; s++) begin
        send_sample(s < 4 ? 4095 : 0);
        checks++; if (trig_out !== m_trig) begin failures++; $display("FAIL lock_trig: got %b expected %b", trig_out, m_trig); end
        checks++; if (o_pv_cnt !== int'(m_pv)) begin failures++; $display("FAIL lock_pv: got %0d expected %0d", o_pv_cnt, m_pv); end
        if (o_pv_cnt != 0) begin
          if (nrep < 9) begin
            checks++; if (o_period !== exp_p[nrep]) begin failures++; $display("FAIL lock_period[%0d]: got %0d expected %0d", nrep, o_period, exp_p[nrep]); end
            checks++; if (stable !== exp_s[nrep]) begin failures++; $display("FAIL lock_stable[%0d]: got %b expected %b", nrep, stable, exp_s[nrep]); end
          end
          nrep++;
        end
      end
    end
    checks++; if (nrep !== 9) begin failures++; $display("FAIL lock_report_count: got %0d expected 9", nrep); end
  endtask

  task automatic test_timeout();
    int npv;
    npv = 0;
    repeat (4) send_sample(0);
    for (int w = 0; w < 7; w++)
      for (int s = 0; s < 8; s++) send_sample(s < 4 ? 4095 : 0);
    for (int k = 1; k <= 70; k++) begin
      send_sample(4095);
      checks++; if (stable !== (k < 63 + FD)) begin failures++; $display("FAIL timeout_stable[%0d]: got %b expected %b", k, stable, (k < 63 + FD)); end
      checks++; if (o_pv_cnt !== ((k == 1 + FD) ? 1 : 0)) begin failures++; $display("FAIL timeout_pv[%0d]: got %0d expected %0d", k, o_pv_cnt, (k == 1 + FD) ? 1 : 0); end
    end
  endtask

  task automatic test_hysteresis();
    int  vals[4] = '{2070, 2080, 2020, 2015};
    bit  exp_t[4] = '{0, 1, 1, 0};
    trig_level = 12'd2048; trig_hyst = 12'd32;
    repeat (2) send_sample(0);
    for (int i = 0; i < 4; i++) begin
      repeat (1 + FD) send_sample(vals[i]);
      checks++; if (trig_out !== exp_t[i]) begin failures++; $display("FAIL hyst_%0d: got %b expected %b", vals[i], trig_out, exp_t[i]); end
    end
  endtask

  task automatic test_saturation();
    int  vals[4] = '{4094, 4095, 3990, 3979};
    bit  exp_t[4] = '{0, 1, 1, 0};
    trig_level = 12'd4080; trig_hyst = 12'd100;
    repeat (2) send_sample(0);
    for (int i = 0; i < 4; i++) begin
      repeat (1 + FD) send_sample(vals[i]);
      checks++; if (trig_out !== exp_t[i]) begin failures++; $display("FAIL sat_%0d: got %b expected %b", vals[i], trig_out, exp_t[i]); end
    end
  endtask

  task automatic test_glitch();
    int vals[3] = '{4095, 0, 0};
`ifdef ADC_TRIG_GLITCH_FILTER_EN
    bit exp_t[3] = '{0, 0, 0};
`else
    bit exp_t[3] = '{1, 0, 0};
`endif
    trig_level = 12'd2048; trig_hyst = 12'd32;
    repeat (3) send_sample(0);
    for (int i = 0; i < 3; i++) begin
      send_sample(vals[i]);
      checks++; if (trig_out !== exp_t[i]) begin failures++; $display("FAIL glitch_%0d: got %b expected %b", i, trig_out, exp_t[i]); end
    end
  endtask

  task automatic test_random();
    int base, len, hi_len, v;
    base = 8;
    for (int w = 0; w < 40; w++) begin
      if (w % 10 == 0) base = int'($urandom_range(3, 12));
      if ($urandom_range(0, 3) == 0) begin
        trig_level = 12'($urandom_range(500, 3500));
        trig_hyst  = 12'($urandom_range(0, 400));
      end
      if ($urandom_range(0, 9) == 0) begin
        len = 70; hi_len = 0;
      end else begin
        len = base + int'($urandom_range(0, 3));
        hi_len = int'($urandom_range(1, len - 1));
      end
      for (int s = 0; s < len; s++) begin
        if ($urandom_range(0, 19) == 0) v = int'($urandom_range(0, 4095));
        else if (s < hi_len) v = 4095 - int'($urandom_range(0, 60));
        else v = int'($urandom_range(0, 60));
        send_sample(v);
        checks++; if (trig_out !== m_trig) begin failures++; $display("FAIL rand_trig: got %b expected %b", trig_out, m_trig); end
        checks++; if (stable !== m_stable) begin failures++; $display("FAIL rand_stable: got %b expected %b", stable, m_stable); end
        checks++; if (o_pv_cnt !== int'(m_pv)) begin failures++; $display("FAIL rand_pv: got %0d expected %0d", o_pv_cnt, m_pv); end
        checks++; if (int'(period) !== m_period) begin failures++; $display("FAIL rand_period: got %0d expected %0d", period, m_period); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int npv;
    trig_level = 12'd2048; trig_hyst = 12'd32;
    repeat (3) send_sample(0);
    for (int w = 0; w < 7; w++)
      for (int s = 0; s < 8; s++) send_sample(s < 4 ? 4095 : 0);
    send_sample(4095); send_sample(4095);
    checks++; if (stable !== 1'b1 || trig_out !== 1'b1) begin
      failures++; $display("FAIL pre_reset_locked: got stable=%b trig=%b expected 1 1", stable, trig_out);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (trig_out !== 1'b0) begin failures++; $display("FAIL midreset_trig: got %b expected 0", trig_out); end
    checks++; if (stable !== 1'b0) begin failures++; $display("FAIL midreset_stable: got %b expected 0", stable); end
    checks++; if (period !== '0) begin failures++; $display("FAIL midreset_period: got %0d expected 0", period); end
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL midreset_pv: got %b expected 0", period_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) send_sample(0);
    npv = 0;
    for (int s = 0; s < 8; s++) begin
      send_sample(s < 4 ? 4095 : 0);
      npv += o_pv_cnt;
    end
    checks++; if (npv !== 0) begin failures++; $display("FAIL first_rise_pv: got %0d expected 0", npv); end
    npv = 0;
    for (int s = 0; s < 2; s++) begin
      send_sample(4095);
      npv += o_pv_cnt;
      if (o_pv_cnt != 0) begin
        checks++; if (o_period !== 8) begin failures++; $display("FAIL after_reset_period: got %0d expected 8", o_period); end
      end
    end
    checks++; if (npv !== 1) begin failures++; $display("FAIL after_reset_pv: got %0d expected 1", npv); end
    checks++; if (stable !== 1'b0) begin failures++; $display("FAIL after_reset_stable: got %b expected 0", stable); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_timeout();
    test_hysteresis();
    test_saturation();
    test_glitch();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
